mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the five-stage pipeline, directly downstream of the EX/MEM pipeline register. It does three things:
- Resolves the branch decision from the EX/MEM outputs.
- Performs loads and stores through a variable-latency data-memory request/ready handshake, stalling the upstream pipeline while an access is outstanding.
- Registers the write-back result into an internal MEM/WB register.

Misaligned accesses and memory timeouts are converted into bubbles and flagged on a sticky error output.

## Interface
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without `mem_Ready` before the access is aborted (1..65535).
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; while low all state and outputs are held at reset values.
- in_Valid  in  1  EX/MEM slot holds a real instruction.
- in_Zero  in  1  ALU zero flag.
- in_ALUResult  in  32  ALU result / memory address.
- in_ReadData2  in  32  store data.
- in_NewPC  in  32  branch target.
- in_CtrlMemRead, in_CtrlMemWrite, in_CtrlBranch  in  1 each  control bits.
- in_CtrlALUOrMem  in  1  write-back select: 1 = memory data, 0 = ALU result.
- in_CtrlRegWrite  in  1  register write enable.
- in_WriteReg  in  5  destination register.
- mem_Req  out  1  request to data memory.
- mem_We  out  1  request is a write.
- mem_Addr, mem_WData  out  32  address and write data, stable while `mem_Req`=1.
- mem_Ready  in  1  memory completes the request this cycle; `mem_RData` is valid when this is high.
- mem_RData  in  32  read data.
- out_Stall  out  1  hold IF/ID/EX and EX/MEM this cycle.
- out_PCSrc  out  1  take the branch.
- out_BranchTarget  out  32  target PC for the taken branch.
- out_WBValid, out_RegWrite  out  1  MEM/WB valid flag and register write enable.
- out_WBData  out  32  selected write-back value.
- out_WriteReg  out  5  MEM/WB destination register.
- out_MemError  out  1  sticky error flag.

## Operation
- Memory op = `in_Valid & (in_CtrlMemRead | in_CtrlMemWrite)`. If both read and write are set, the op is treated as a write.
- FSM states: IDLE, ACCESS.
- IDLE, no memory op:
  - MEM/WB captures `out_WBValid=in_Valid`, `RegWrite=in_Valid&in_CtrlRegWrite`, `WriteReg`, `WBData=in_ALUResult`.
  - No stall.
- IDLE, memory op, `in_ALUResult[1:0]==0`:
  - `out_Stall=1`; MEM/WB loads a bubble (valid=0, RegWrite=0).
  - On the edge: latch address, `ReadData2` and write flag; go to ACCESS; clear the timeout counter.
- IDLE, memory op, misaligned:
  - No request and no stall.
  - MEM/WB gets `valid=1`, `RegWrite=0`, `WBData=in_ALUResult`.
  - `out_MemError` set.
- ACCESS:
  - `mem_Req=1`; `mem_Addr`, `mem_WData` and `mem_We` come from the latches.
  - `out_Stall = ~mem_Ready & ~timeout`.
  - If `mem_Ready`: MEM/WB gets `valid=1`, `RegWrite=in_CtrlRegWrite`, and `WBData = in_CtrlALUOrMem ? mem_RData : in_ALUResult`; go to IDLE.
  - Otherwise the counter increments. `timeout` is asserted when the counter reaches TIMEOUT_CYCLES−1 with `mem_Ready` low. On timeout: MEM/WB gets a bubble with `valid=1, RegWrite=0`; `out_MemError` set; go to IDLE.
  - `mem_Ready` in the terminal-count cycle wins over timeout.
- `mem_Ready` while in IDLE is ignored.
- `out_PCSrc = in_Valid & in_CtrlBranch & in_Zero & (state==IDLE)`; `out_BranchTarget = in_NewPC`. Both are combinational.
- `out_MemError` is cleared only by reset.

## Timing
- Reset values: state IDLE; `mem_Req`, `mem_We`, `out_Stall` (no valid input), `out_PCSrc`, `out_WBValid`, `out_RegWrite`, `out_MemError` all 0; `mem_Addr`, `mem_WData`, `out_WBData`, `out_BranchTarget` (when `in_NewPC`=0), `out_WriteReg` all 0.
- Reset asserted during ACCESS: `mem_Req` drops immediately (asynchronously) and the access is abandoned.
- Non-memory instruction: result visible on the MEM/WB outputs 1 cycle after presentation.
- Memory op:
  - Cycle 0: stall.
  - Cycles 1..k: ACCESS with `mem_Req` high; `mem_Ready` arrives in cycle k.
  - MEM/WB valid in cycle k+1.
  - `out_Stall` is low in cycle k, so upstream advances on the same edge that completes the access.
  - Minimum load latency is 2 cycles.
- Back-to-back memory ops: the next op enters IDLE-stall in cycle k+1, so there is no duplicate request.
- `mem_Req` is registered; `mem_Addr` and `mem_WData` never change while `mem_Req`=1.

## Test plan
- Load: addr 0x10 with `mem_Ready` high on the first ACCESS cycle, `mem_RData=0xDEADBEEF` -> stall cycle 0 only, `mem_Req` in cycle 1, `out_WBData=0xDEADBEEF` and `out_RegWrite=1` in cycle 2.
- Store: addr 0x20, data 0x1234, `mem_Ready` after 3 ACCESS cycles -> `mem_We=1` with addr and data stable for 3 cycles, `out_Stall` high for cycles 0–2 and low in cycle 3, MEM/WB valid in cycle 4 with `RegWrite=0`.
- Misaligned load: addr 0x13 -> no `mem_Req`, no stall, `out_WBValid=1`, `RegWrite=0`, `out_MemError=1` and it stays 1.
- Timeout: TIMEOUT_CYCLES=4, `mem_Ready` held low -> stall for cycles 0–3 (low in cycle 4), `mem_Req` deasserted after 4 ACCESS cycles, bubble written, error set. Repeat with `mem_Ready` in the 4th ACCESS cycle -> normal completion, no error.
- Branch: `in_Valid=1`, `in_CtrlBranch=1`, `in_Zero=1`, `in_NewPC=0x40` -> `out_PCSrc=1` and `out_BranchTarget=0x40` in the same cycle; with `in_Zero=0` -> `out_PCSrc=0`.
- Reset low mid-ACCESS -> `mem_Req`, `out_Stall`, `out_WBValid` and `out_MemError` all 0 immediately; after release the next ALU op passes through normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the five-stage pipeline.
// Resolves the branch, performs loads/stores over a req/ready handshake
// (stalling upstream while an access is outstanding) and registers the
// write-back result into the MEM/WB register. Misaligned accesses and
// memory timeouts become bubbles and set a sticky error flag.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   in_*                  EX/MEM pipeline register contents
//   mem_Req/We/Addr/WData data-memory request (registered)
//   mem_Ready/RData       data-memory completion and read data
//   out_Stall             hold IF/ID/EX and EX/MEM this cycle
//   out_PCSrc/BranchTarget branch decision and target
//   out_WB*/RegWrite/WriteReg MEM/WB register
//   out_MemError          sticky misalign/timeout flag
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_Valid,
  input  logic        in_Zero,
  input  logic [31:0] in_ALUResult,
  input  logic [31:0] in_ReadData2,
  input  logic [31:0] in_NewPC,
  input  logic        in_CtrlMemRead,
  input  logic        in_CtrlMemWrite,
  input  logic        in_CtrlBranch,
  input  logic        in_CtrlALUOrMem,
  input  logic        in_CtrlRegWrite,
  input  logic [4:0]  in_WriteReg,
  output logic        mem_Req,
  output logic        mem_We,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_WData,
  input  logic        mem_Ready,
  input  logic [31:0] mem_RData,
  output logic        out_Stall,
  output logic        out_PCSrc,
  output logic [31:0] out_BranchTarget,
  output logic        out_WBValid,
  output logic        out_RegWrite,
  output logic [31:0] out_WBData,
  output logic [4:0]  out_WriteReg,
  output logic        out_MemError
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TERM  = TIMEOUT_CYCLES - 1;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wb_valid_q, wb_valid_d;
  logic               reg_write_q, reg_write_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic               err_q, err_d;
  logic               stall_c;

  logic mem_op_c;
  logic aligned_c;
  logic timeout_c;

  assign mem_op_c  = in_Valid & (in_CtrlMemRead | in_CtrlMemWrite);
  assign aligned_c = (in_ALUResult[1:0] == 2'b00);
  // Terminal-count cycle with no ready; ready in the same cycle wins.
  assign timeout_c = (state_q == ST_ACCESS) & ~mem_Ready &
                     (cnt_q == CNT_W'(TERM));

  // State and pipeline registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      cnt_q       <= '0;
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      wb_data_q   <= 32'h0;
      write_reg_q <= 5'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      wb_valid_q  <= wb_valid_d;
      reg_write_q <= reg_write_d;
      wb_data_q   <= wb_data_d;
      write_reg_q <= write_reg_d;
      err_q       <= err_d;
    end
  end

  // Next-state, MEM/WB capture and stall
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    wb_valid_d  = in_Valid;
    reg_write_d = in_Valid & in_CtrlRegWrite;
    wb_data_d   = in_ALUResult;
    write_reg_d = in_WriteReg;
    err_d       = err_q;
    stall_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op_c) begin
          if (aligned_c) begin
            stall_c     = 1'b1;
            wb_valid_d  = 1'b0;
            reg_write_d = 1'b0;
            addr_d      = in_ALUResult;
            wdata_d     = in_ReadData2;
            we_d        = in_CtrlMemWrite;
            cnt_d       = '0;
            req_d       = 1'b1;
            state_d     = ST_ACCESS;
          end else begin
            reg_write_d = 1'b0;
            err_d       = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_Ready) begin
          wb_valid_d  = 1'b1;
          reg_write_d = in_CtrlRegWrite;
          wb_data_d   = in_CtrlALUOrMem ? mem_RData : in_ALUResult;
          req_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = ST_IDLE;
        end else if (timeout_c) begin
          wb_valid_d  = 1'b1;
          reg_write_d = 1'b0;
          err_d       = 1'b1;
          req_d       = 1'b0;
          we_d        = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          stall_c     = 1'b1;
          wb_valid_d  = 1'b0;
          reg_write_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Combinational controls are forced low while reset is held.
  assign out_Stall        = reset & stall_c;
  assign out_PCSrc        = reset & in_Valid & in_CtrlBranch & in_Zero &
                            (state_q == ST_IDLE);
  assign out_BranchTarget = in_NewPC;

  assign mem_Req      = req_q;
  assign mem_We       = we_q;
  assign mem_Addr     = addr_q;
  assign mem_WData    = wdata_q;
  assign out_WBValid  = wb_valid_q;
  assign out_RegWrite = reg_write_q;
  assign out_WBData   = wb_data_q;
  assign out_WriteReg = write_reg_q;
  assign out_MemError = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_Valid, in_Zero;
  logic [31:0] in_ALUResult, in_ReadData2, in_NewPC;
  logic        in_CtrlMemRead, in_CtrlMemWrite, in_CtrlBranch;
  logic        in_CtrlALUOrMem, in_CtrlRegWrite;
  logic [4:0]  in_WriteReg;
  logic        mem_Req, mem_We;
  logic [31:0] mem_Addr, mem_WData;
  logic        mem_Ready;
  logic [31:0] mem_RData;
  logic        out_Stall, out_PCSrc;
  logic [31:0] out_BranchTarget;
  logic        out_WBValid, out_RegWrite;
  logic [31:0] out_WBData;
  logic [4:0]  out_WriteReg;
  logic        out_MemError;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_Valid(in_Valid), .in_Zero(in_Zero),
    .in_ALUResult(in_ALUResult), .in_ReadData2(in_ReadData2),
    .in_NewPC(in_NewPC),
    .in_CtrlMemRead(in_CtrlMemRead), .in_CtrlMemWrite(in_CtrlMemWrite),
    .in_CtrlBranch(in_CtrlBranch), .in_CtrlALUOrMem(in_CtrlALUOrMem),
    .in_CtrlRegWrite(in_CtrlRegWrite), .in_WriteReg(in_WriteReg),
    .mem_Req(mem_Req), .mem_We(mem_We), .mem_Addr(mem_Addr),
    .mem_WData(mem_WData), .mem_Ready(mem_Ready), .mem_RData(mem_RData),
    .out_Stall(out_Stall), .out_PCSrc(out_PCSrc),
    .out_BranchTarget(out_BranchTarget),
    .out_WBValid(out_WBValid), .out_RegWrite(out_RegWrite),
    .out_WBData(out_WBData), .out_WriteReg(out_WriteReg),
    .out_MemError(out_MemError)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    in_Valid = 0; in_Zero = 0; in_ALUResult = 0; in_ReadData2 = 0;
    in_NewPC = 0; in_CtrlMemRead = 0; in_CtrlMemWrite = 0;
    in_CtrlBranch = 0; in_CtrlALUOrMem = 0; in_CtrlRegWrite = 0;
    in_WriteReg = 0; mem_Ready = 0; mem_RData = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    #2;
    reset = 1;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] wr);
    clear_in();
    in_Valid = 1; in_CtrlMemRead = 1; in_CtrlRegWrite = 1;
    in_CtrlALUOrMem = 1; in_ALUResult = addr; in_WriteReg = wr;
  endtask

  initial begin
    reset = 0;
    clear_in();
    #2;
    check("rst_req", 32'(mem_Req), 0);
    check("rst_stall", 32'(out_Stall), 0);
    check("rst_wbvalid", 32'(out_WBValid), 0);
    check("rst_err", 32'(out_MemError), 0);
    check("rst_wbdata", out_WBData, 0);
    check("rst_addr", mem_Addr, 0);
    #10 reset = 1;

    // ALU pass-through
    tick();
    clear_in();
    in_Valid = 1; in_CtrlRegWrite = 1; in_ALUResult = 32'h55; in_WriteReg = 3;
    #1 check("alu_stall", 32'(out_Stall), 0);
    tick();
    clear_in();
    #1;
    check("alu_wbvalid", 32'(out_WBValid), 1);
    check("alu_regwrite", 32'(out_RegWrite), 1);
    check("alu_wbdata", out_WBData, 32'h55);
    check("alu_wreg", 32'(out_WriteReg), 3);

    // Load, ready on first ACCESS cycle
    set_load(32'h10, 5);
    #1;
    check("ld_c0_stall", 32'(out_Stall), 1);
    check("ld_c0_req", 32'(mem_Req), 0);
    tick();
    #1;
    check("ld_c1_req", 32'(mem_Req), 1);
    check("ld_c1_addr", mem_Addr, 32'h10);
    check("ld_c1_we", 32'(mem_We), 0);
    check("ld_c1_wbvalid", 32'(out_WBValid), 0);
    mem_Ready = 1; mem_RData = 32'hDEADBEEF;
    #1 check("ld_c1_stall", 32'(out_Stall), 0);
    tick();
    clear_in();
    #1;
    check("ld_c2_wbdata", out_WBData, 32'hDEADBEEF);
    check("ld_c2_regwrite", 32'(out_RegWrite), 1);
    check("ld_c2_wbvalid", 32'(out_WBValid), 1);
    check("ld_c2_wreg", 32'(out_WriteReg), 5);
    check("ld_c2_req", 32'(mem_Req), 0);

    // Store, ready on third ACCESS cycle
    clear_in();
    in_Valid = 1; in_CtrlMemWrite = 1; in_ALUResult = 32'h20;
    in_ReadData2 = 32'h1234;
    #1 check("st_c0_stall", 32'(out_Stall), 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) mem_Ready = 1;
      #1;
      check("st_req", 32'(mem_Req), 1);
      check("st_we", 32'(mem_We), 1);
      check("st_addr", mem_Addr, 32'h20);
      check("st_wdata", mem_WData, 32'h1234);
      check("st_stall", 32'(out_Stall), (i < 3) ? 1 : 0);
    end
    tick();
    clear_in();
    #1;
    check("st_c4_wbvalid", 32'(out_WBValid), 1);
    check("st_c4_regwrite", 32'(out_RegWrite), 0);
    check("st_c4_req", 32'(mem_Req), 0);

    // Misaligned load
    set_load(32'h13, 6);
    #1;
    check("mis_stall", 32'(out_Stall), 0);
    check("mis_req0", 32'(mem_Req), 0);
    tick();
    clear_in();
    #1;
    check("mis_req1", 32'(mem_Req), 0);
    check("mis_wbvalid", 32'(out_WBValid), 1);
    check("mis_regwrite", 32'(out_RegWrite), 0);
    check("mis_wbdata", out_WBData, 32'h13);
    check("mis_err", 32'(out_MemError), 1);
    tick();
    tick();
    check("mis_err_sticky", 32'(out_MemError), 1);

    // Reset asserted mid-ACCESS
    set_load(32'h30, 2);
    tick();
    #1 check("rma_req_before", 32'(mem_Req), 1);
    #1 reset = 0;
    #1;
    check("rma_req", 32'(mem_Req), 0);
    check("rma_stall", 32'(out_Stall), 0);
    check("rma_wbvalid", 32'(out_WBValid), 0);
    check("rma_err", 32'(out_MemError), 0);
    clear_in();
    in_Valid = 1; in_CtrlRegWrite = 1; in_ALUResult = 32'h77; in_WriteReg = 7;
    #1 reset = 1;
    tick();
    clear_in();
    #1;
    check("rma_alu_wbvalid", 32'(out_WBValid), 1);
    check("rma_alu_wbdata", out_WBData, 32'h77);
    check("rma_alu_wreg", 32'(out_WriteReg), 7);
    check("rma_alu_req", 32'(mem_Req), 0);

    // Timeout with ready held low
    set_load(32'h40, 9);
    #1 check("to_c0_stall", 32'(out_Stall), 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      #1;
      check("to_req", 32'(mem_Req), 1);
      check("to_stall", 32'(out_Stall), (i < 4) ? 1 : 0);
    end
    tick();
    clear_in();
    #1;
    check("to_req_drop", 32'(mem_Req), 0);
    check("to_wbvalid", 32'(out_WBValid), 1);
    check("to_regwrite", 32'(out_RegWrite), 0);
    check("to_err", 32'(out_MemError), 1);
    pulse_reset();
    #1 check("to_err_clr", 32'(out_MemError), 0);

    // Ready in the terminal-count cycle, then back-to-back load
    set_load(32'h44, 10);
    mem_RData = 32'hCAFEF00D;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) mem_Ready = 1;
      #1;
      check("tc_req", 32'(mem_Req), 1);
      check("tc_stall", 32'(out_Stall), (i < 4) ? 1 : 0);
    end
    tick();
    set_load(32'h48, 11);
    #1;
    check("tc_wbvalid", 32'(out_WBValid), 1);
    check("tc_regwrite", 32'(out_RegWrite), 1);
    check("tc_wbdata", out_WBData, 32'hCAFEF00D);
    check("tc_err", 32'(out_MemError), 0);
    check("b2b_req", 32'(mem_Req), 0);
    check("b2b_stall", 32'(out_Stall), 1);
    tick();
    #1;
    check("b2b_req1", 32'(mem_Req), 1);
    check("b2b_addr", mem_Addr, 32'h48);
    check("b2b_pcsrc_access", 32'(out_PCSrc), 0);
    mem_Ready = 1;
    tick();
    clear_in();
    #1 check("b2b_done_req", 32'(mem_Req), 0);

    // Branch resolution
    clear_in();
    in_Valid = 1; in_CtrlBranch = 1; in_Zero = 1; in_NewPC = 32'h40;
    #1;
    check("br_pcsrc", 32'(out_PCSrc), 1);
    check("br_target", out_BranchTarget, 32'h40);
    in_Zero = 0;
    #1 check("br_nottaken", 32'(out_PCSrc), 0);
    tick();
    clear_in();
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
